// File: rtl/fault_injector_seq_if.sv
// Stream bundle between the ECC encoder side and the fault injector, and from the
// injector to the decoder side, plus per-word injection controls and status.
interface fault_injector_seq_if #(
    parameter int unsigned WIDTH = 72,
    parameter int unsigned POS_W = 7,
    parameter int unsigned CNT_W = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] IN;
    logic [2:0]       mode;
    logic [POS_W-1:0] pos0;
    logic [POS_W-1:0] pos1;
    logic [CNT_W-1:0] period;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] OUT;
    logic [WIDTH-1:0] flip_mask;
    logic [CNT_W-1:0] inj_count;

    modport master (
        output in_valid, IN, mode, pos0, pos1, period, out_ready,
        input  in_ready, out_valid, OUT, flip_mask, inj_count
    );

    modport slave (
        input  in_valid, IN, mode, pos0, pos1, period, out_ready,
        output in_ready, out_valid, OUT, flip_mask, inj_count
    );
endinterface

// File: rtl/fault_injector_seq.sv
// One-stage pipelined fault injector: XORs a per-word fault mask (fixed positions,
// burst, LFSR-random or periodic) into each accepted codeword.
module fault_injector_seq #(
    parameter int unsigned WIDTH = 72,
    parameter int unsigned POS_W = 7,
    parameter int unsigned BURST = 4,
    parameter logic [15:0] SEED  = 16'hACE1,
    parameter int unsigned CNT_W = 16
) (
    input logic                 clk,
    input logic                 rst,
    fault_injector_seq_if.slave bus
);

    typedef enum logic [2:0] {
        MODE_PASS     = 3'b000,
        MODE_SINGLE   = 3'b001,
        MODE_DOUBLE   = 3'b010,
        MODE_RAND1    = 3'b011,
        MODE_RAND2    = 3'b100,
        MODE_BURST    = 3'b101,
        MODE_PERIODIC = 3'b110,
        MODE_RSVD     = 3'b111
    } mode_t;

    localparam logic [CNT_W-1:0] CNT_ONE = 1;

    mode_t            mode_in;
    logic             accept;
    logic             out_valid_q;
    logic [WIDTH-1:0] out_q;
    logic [WIDTH-1:0] flip_q;
    logic [WIDTH-1:0] mask;
    logic [CNT_W-1:0] inj_q;
    logic [CNT_W-1:0] per_cnt_q;
    logic             per_hit;
    logic [15:0]      lfsr_q;
    logic [15:0]      lfsr_next;
    logic [31:0]      p0;
    logic [31:0]      p1;
    logic [31:0]      r0;
    logic [31:0]      r1;

    function automatic logic [WIDTH-1:0] bit_at(input logic [31:0] p);
        logic [WIDTH-1:0] m;
        m = '0;
        for (int i = 0; i < WIDTH; i++) begin
            if (p == 32'(i)) m[i] = 1'b1;
        end
        return m;
    endfunction

    function automatic logic [WIDTH-1:0] burst_at(input logic [31:0] p);
        logic [WIDTH-1:0] m;
        m = '0;
        if (p < WIDTH) begin
            for (int k = 0; k < BURST; k++) begin
                m = m | bit_at((p + 32'(k)) % WIDTH);
            end
        end
        return m;
    endfunction

    assign mode_in   = mode_t'(bus.mode);
    assign accept    = bus.in_valid && bus.in_ready;
    assign p0        = 32'(bus.pos0);
    assign p1        = 32'(bus.pos1);
    assign lfsr_next = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};

    // r1 is offset from r0 by 1..WIDTH-1, so the two random positions never coincide
    assign r0 = 32'(lfsr_q) % WIDTH;
    assign r1 = (r0 + 32'd1 + (32'(lfsr_q[15:8]) % (WIDTH - 1))) % WIDTH;

    assign per_hit = (bus.period != '0) && (per_cnt_q == bus.period - CNT_ONE);

    always_comb begin
        mask = '0;
        case (mode_in)
            MODE_SINGLE:   mask = bit_at(p0);
            MODE_DOUBLE:   mask = bit_at(p0) | bit_at(p1);
            MODE_RAND1:    mask = bit_at(r0);
            MODE_RAND2:    mask = bit_at(r0) | bit_at(r1);
            MODE_BURST:    mask = burst_at(p0);
            MODE_PERIODIC: mask = per_hit ? bit_at(r0) : '0;
            default:       mask = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            out_q       <= '0;
            flip_q      <= '0;
            inj_q       <= '0;
            per_cnt_q   <= '0;
            lfsr_q      <= SEED;
        end else if (accept) begin
            out_q       <= bus.IN ^ mask;
            flip_q      <= mask;
            out_valid_q <= 1'b1;
            lfsr_q      <= lfsr_next;
            if ((mask != '0) && (inj_q != '1)) inj_q <= inj_q + CNT_ONE;
            if (mode_in == MODE_PERIODIC) begin
                if ((bus.period == '0) || per_hit) per_cnt_q <= '0;
                else                               per_cnt_q <= per_cnt_q + CNT_ONE;
            end else begin
                per_cnt_q <= '0;
            end
        end else if (bus.out_ready) begin
            out_valid_q <= 1'b0;
        end
    end

    assign bus.in_ready  = !out_valid_q || bus.out_ready;
    assign bus.out_valid = out_valid_q;
    assign bus.OUT       = out_q;
    assign bus.flip_mask = flip_q;
    assign bus.inj_count = inj_q;

endmodule

// File: tb/tb_fault_injector_seq.sv
// Directed bench for fault_injector_seq with a small LFSR reference for random modes.
module tb_fault_injector_seq;

    localparam int W  = 72;
    localparam int PW = 7;
    localparam int CW = 16;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    fault_injector_seq_if #(.WIDTH(W), .POS_W(PW), .CNT_W(CW)) bus();

    fault_injector_seq #(
        .WIDTH(W), .POS_W(PW), .BURST(4), .SEED(16'hACE1), .CNT_W(CW)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int            vec_cnt = 0;
    int            err_cnt = 0;
    logic [15:0]   lfsr_m;
    logic [CW-1:0] inj_exp;

    function automatic logic [W-1:0] bm(input int p);
        logic [W-1:0] one;
        one = 1;
        if (p >= 0 && p < W) return one << p;
        return '0;
    endfunction

    function automatic int mr0(input logic [15:0] l);
        return int'(l) % W;
    endfunction

    function automatic int mr1(input logic [15:0] l);
        return (mr0(l) + 1 + (int'(l[15:8]) % (W - 1))) % W;
    endfunction

    task automatic adv();
        lfsr_m = {lfsr_m[14:0], lfsr_m[15] ^ lfsr_m[13] ^ lfsr_m[12] ^ lfsr_m[10]};
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [W-1:0] d, input logic [2:0] m, input int a, input int b);
        logic [31:0] av, bv;
        av = a;
        bv = b;
        bus.IN        = d;
        bus.mode      = m;
        bus.pos0      = av[PW-1:0];
        bus.pos1      = bv[PW-1:0];
        bus.in_valid  = 1'b1;
        bus.out_ready = 1'b1;
    endtask

    // one accepted word with out_ready high; the model LFSR advances with it
    task automatic send(input logic [W-1:0] d, input logic [2:0] m, input int a, input int b);
        drive(d, m, a, b);
        step();
        adv();
        bus.in_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step();
        step();
        vec_cnt++; if (bus.out_valid !== 1'b0) begin err_cnt++; $display("FAIL reset_out_valid got=%b exp=0", bus.out_valid); end
        vec_cnt++; if (bus.OUT !== '0) begin err_cnt++; $display("FAIL reset_OUT got=%h exp=0", bus.OUT); end
        vec_cnt++; if (bus.flip_mask !== '0) begin err_cnt++; $display("FAIL reset_flip_mask got=%h exp=0", bus.flip_mask); end
        vec_cnt++; if (bus.inj_count !== '0) begin err_cnt++; $display("FAIL reset_inj_count got=%0d exp=0", bus.inj_count); end
        rst = 1'b0;
        lfsr_m = 16'hACE1;
        inj_exp = '0;
    endtask

    task automatic test_pass();
        drive('0, 3'b000, 0, 0);
        #1;
        vec_cnt++; if (bus.in_ready !== 1'b1) begin err_cnt++; $display("FAIL pass_in_ready_pre got=%b exp=1", bus.in_ready); end
        step(); adv(); bus.in_valid = 1'b0;
        vec_cnt++; if (bus.out_valid !== 1'b1) begin err_cnt++; $display("FAIL pass_out_valid got=%b exp=1", bus.out_valid); end
        vec_cnt++; if (bus.OUT !== '0) begin err_cnt++; $display("FAIL pass_OUT got=%h exp=0", bus.OUT); end
        vec_cnt++; if (bus.flip_mask !== '0) begin err_cnt++; $display("FAIL pass_flip_mask got=%h exp=0", bus.flip_mask); end
        vec_cnt++; if (bus.inj_count !== '0) begin err_cnt++; $display("FAIL pass_inj_count got=%0d exp=0", bus.inj_count); end
        vec_cnt++; if (bus.in_ready !== 1'b1) begin err_cnt++; $display("FAIL pass_in_ready got=%b exp=1", bus.in_ready); end
    endtask

    task automatic test_positions();
        send('0, 3'b001, 5, 0);
        inj_exp++;
        vec_cnt++; if (bus.OUT !== 72'h20) begin err_cnt++; $display("FAIL single_pos5 got=%h exp=%h", bus.OUT, 72'h20); end
        vec_cnt++; if (bus.inj_count !== inj_exp) begin err_cnt++; $display("FAIL single_inj got=%0d exp=%0d", bus.inj_count, inj_exp); end
        send(72'h1, 3'b010, 0, 71);
        inj_exp++;
        vec_cnt++; if (bus.OUT !== bm(71)) begin err_cnt++; $display("FAIL double_0_71 got=%h exp=%h", bus.OUT, bm(71)); end
        vec_cnt++; if (bus.flip_mask !== (bm(0) | bm(71))) begin err_cnt++; $display("FAIL double_mask got=%h exp=%h", bus.flip_mask, bm(0) | bm(71)); end
        send('0, 3'b010, 3, 3);
        inj_exp++;
        vec_cnt++; if (bus.OUT !== bm(3)) begin err_cnt++; $display("FAIL double_same_pos got=%h exp=%h", bus.OUT, bm(3)); end
        send('0, 3'b001, 100, 0);
        vec_cnt++; if (bus.flip_mask !== '0) begin err_cnt++; $display("FAIL single_out_of_range got=%h exp=0", bus.flip_mask); end
        vec_cnt++; if (bus.inj_count !== inj_exp) begin err_cnt++; $display("FAIL zero_mask_inj got=%0d exp=%0d", bus.inj_count, inj_exp); end
        send('1, 3'b111, 5, 6);
        vec_cnt++; if (bus.OUT !== {W{1'b1}} || bus.flip_mask !== '0) begin err_cnt++; $display("FAIL reserved_mode got=%h/%h exp=all-ones/0", bus.OUT, bus.flip_mask); end
    endtask

    task automatic test_burst();
        send('0, 3'b101, 70, 0);
        inj_exp++;
        vec_cnt++; if (bus.flip_mask !== (bm(70) | bm(71) | bm(0) | bm(1))) begin err_cnt++; $display("FAIL burst_wrap got=%h exp=%h", bus.flip_mask, bm(70) | bm(71) | bm(0) | bm(1)); end
        send(72'hFFFF, 3'b101, 10, 0);
        inj_exp++;
        vec_cnt++; if (bus.OUT !== (72'hFFFF ^ (bm(10) | bm(11) | bm(12) | bm(13)))) begin err_cnt++; $display("FAIL burst_mid got=%h", bus.OUT); end
        send('0, 3'b101, 72, 0);
        vec_cnt++; if (bus.flip_mask !== '0) begin err_cnt++; $display("FAIL burst_out_of_range got=%h exp=0", bus.flip_mask); end
        vec_cnt++; if (bus.inj_count !== inj_exp) begin err_cnt++; $display("FAIL burst_inj got=%0d exp=%0d", bus.inj_count, inj_exp); end
    endtask

    task automatic test_random();
        logic [95:0]  rnd;
        logic [W-1:0] d, exp_m;
        for (int n = 0; n < 1000; n++) begin
            rnd   = {$urandom, $urandom, $urandom};
            d     = rnd[W-1:0];
            exp_m = bm(mr0(lfsr_m)) | bm(mr1(lfsr_m));
            drive(d, 3'b100, 0, 0);
            step();
            adv();
            inj_exp++;
            vec_cnt++; if (bus.OUT !== (d ^ exp_m) || $countones(bus.flip_mask) != 2) begin
                err_cnt++; $display("FAIL rand2_word%0d got=%h exp=%h", n, bus.flip_mask, exp_m);
            end
        end
        for (int n = 0; n < 8; n++) begin
            exp_m = bm(mr0(lfsr_m));
            drive('0, 3'b011, 0, 0);
            step();
            adv();
            inj_exp++;
            vec_cnt++; if (bus.flip_mask !== exp_m) begin err_cnt++; $display("FAIL rand1_word%0d got=%h exp=%h", n, bus.flip_mask, exp_m); end
        end
        bus.in_valid = 1'b0;
        vec_cnt++; if (bus.inj_count !== inj_exp) begin err_cnt++; $display("FAIL rand_inj got=%0d exp=%0d", bus.inj_count, inj_exp); end
    endtask

    task automatic test_periodic();
        logic [W-1:0] exp_m;
        bus.period = 16'd3;
        for (int i = 0; i < 9; i++) begin
            exp_m = (i % 3 == 2) ? bm(mr0(lfsr_m)) : '0;
            if (exp_m != '0) inj_exp++;
            send('0, 3'b110, 0, 0);
            vec_cnt++; if (bus.flip_mask !== exp_m) begin err_cnt++; $display("FAIL periodic3_word%0d got=%h exp=%h", i + 1, bus.flip_mask, exp_m); end
        end
        vec_cnt++; if (bus.inj_count !== inj_exp) begin err_cnt++; $display("FAIL periodic3_inj got=%0d exp=%0d", bus.inj_count, inj_exp); end
        bus.period = 16'd0;
        for (int i = 0; i < 6; i++) begin
            send('0, 3'b110, 0, 0);
            vec_cnt++; if (bus.flip_mask !== '0) begin err_cnt++; $display("FAIL periodic0_word%0d got=%h exp=0", i + 1, bus.flip_mask); end
        end
        // two mode-110 words, then a pass word must restart the count
        bus.period = 16'd3;
        send('0, 3'b110, 0, 0);
        send('0, 3'b110, 0, 0);
        send('0, 3'b000, 0, 0);
        for (int i = 0; i < 3; i++) begin
            exp_m = (i == 2) ? bm(mr0(lfsr_m)) : '0;
            if (exp_m != '0) inj_exp++;
            send('0, 3'b110, 0, 0);
            vec_cnt++; if (bus.flip_mask !== exp_m) begin err_cnt++; $display("FAIL periodic_clear_word%0d got=%h exp=%h", i + 1, bus.flip_mask, exp_m); end
        end
        vec_cnt++; if (bus.inj_count !== inj_exp) begin err_cnt++; $display("FAIL periodic_inj got=%0d exp=%0d", bus.inj_count, inj_exp); end
    endtask

    task automatic test_back_to_back();
        logic [W-1:0] d2, exp2;
        send(72'hFF, 3'b001, 8, 0);
        inj_exp++;
        d2 = 72'hA5_0000_0000_0000_005A;
        drive(d2, 3'b011, 0, 0);
        bus.out_ready = 1'b0;
        #1;
        vec_cnt++; if (bus.in_ready !== 1'b0) begin err_cnt++; $display("FAIL stall_in_ready got=%b exp=0", bus.in_ready); end
        for (int c = 0; c < 3; c++) begin
            step();
            vec_cnt++; if (bus.OUT !== 72'h1FF || bus.flip_mask !== bm(8) || bus.out_valid !== 1'b1) begin
                err_cnt++; $display("FAIL stall_hold_cycle%0d got=%h/%h/%b exp=%h/%h/1", c, bus.OUT, bus.flip_mask, bus.out_valid, 72'h1FF, bm(8));
            end
            vec_cnt++; if (bus.in_ready !== 1'b0) begin err_cnt++; $display("FAIL stall_in_ready_cycle%0d got=%b exp=0", c, bus.in_ready); end
        end
        exp2 = bm(mr0(lfsr_m));
        bus.out_ready = 1'b1;
        step();
        adv();
        inj_exp++;
        bus.in_valid = 1'b0;
        vec_cnt++; if (bus.OUT !== (d2 ^ exp2)) begin err_cnt++; $display("FAIL stall_release got=%h exp=%h", bus.OUT, d2 ^ exp2); end
        step();
        vec_cnt++; if (bus.out_valid !== 1'b0) begin err_cnt++; $display("FAIL drain_out_valid got=%b exp=0", bus.out_valid); end
        vec_cnt++; if (bus.inj_count !== inj_exp) begin err_cnt++; $display("FAIL b2b_inj got=%0d exp=%0d", bus.inj_count, inj_exp); end
    endtask

    task automatic test_reset_mid_stall();
        send('0, 3'b001, 2, 0);
        drive(72'h3, 3'b001, 9, 0);
        bus.out_ready = 1'b0;
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b1;
        vec_cnt++; if (bus.out_valid !== 1'b0) begin err_cnt++; $display("FAIL midstall_rst_valid got=%b exp=0", bus.out_valid); end
        vec_cnt++; if (bus.inj_count !== '0) begin err_cnt++; $display("FAIL midstall_rst_inj got=%0d exp=0", bus.inj_count); end
        vec_cnt++; if (bus.OUT !== '0 || bus.flip_mask !== '0) begin err_cnt++; $display("FAIL midstall_rst_data got=%h/%h exp=0/0", bus.OUT, bus.flip_mask); end
        lfsr_m = 16'hACE1;
        send('0, 3'b011, 0, 0);
        vec_cnt++; if (bus.flip_mask !== bm(49)) begin err_cnt++; $display("FAIL seed_after_reset got=%h exp=%h", bus.flip_mask, bm(49)); end
        vec_cnt++; if (bus.inj_count !== 16'd1) begin err_cnt++; $display("FAIL inj_after_reset got=%0d exp=1", bus.inj_count); end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        bus.IN        = '0;
        bus.mode      = 3'b000;
        bus.pos0      = '0;
        bus.pos1      = '0;
        bus.period    = '0;
        test_reset();
        test_pass();
        test_positions();
        test_burst();
        test_random();
        test_periodic();
        test_back_to_back();
        test_reset_mid_stall();
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule

// File: doc/fault_injector_seq.md
Name: fault_injector_seq

Overview:
Pipelined, parametrised successor to the combinational 72-bit fault injector. Accepts one codeword per valid/ready handshake, XORs a fault mask chosen by a per-word mode, and presents the corrupted word one cycle later. Adds explicit positions, multi-bit bursts, periodic injection, an internal LFSR and an injection counter. Sits between the ECC encoder and decoder in the cache ECC test harness.

Parameters:
WIDTH, 72, codeword width in bits (>=2)
POS_W, 7, width of position inputs (2^POS_W >= WIDTH)
BURST, 4, adjacent bits flipped in burst mode (1..WIDTH)
SEED, 16'hACE1, LFSR reset value (must be nonzero)
CNT_W, 16, width of inj_count and period

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  synchronous reset, active-high
in_valid  in  1  input word valid
in_ready  out  1  block can accept a word
IN  in  WIDTH  input codeword
mode  in  3  injection mode, sampled at accept
pos0  in  POS_W  first fault position / burst start
pos1  in  POS_W  second fault position
period  in  CNT_W  periodic-mode interval in words
out_valid  out  1  OUT valid
out_ready  in  1  downstream accepts OUT
OUT  out  WIDTH  IN XOR flip_mask
flip_mask  out  WIDTH  mask applied to the current OUT
inj_count  out  CNT_W  words emitted with nonzero mask, saturating

Behaviour:
- Reset (rst=1 at edge): out_valid=0, OUT=0, flip_mask=0, inj_count=0, lfsr=SEED, per_cnt=0. Any held word is dropped.
- in_ready = !out_valid || out_ready (combinational). accept = in_valid && in_ready.
- On accept: OUT <= IN ^ mask, flip_mask <= mask, out_valid <= 1. Latency is 1 cycle. Throughput is 1 word/cycle when out_ready=1.
- When out_valid && out_ready && !accept: out_valid <= 0. When stalled (out_valid && !out_ready): OUT, flip_mask and out_valid hold.
- mask is a set of bits (OR of one-hot terms), so coincident positions yield one flip. A position >= WIDTH contributes nothing.
- LFSR: 16-bit Fibonacci. fb = l[15]^l[13]^l[12]^l[10]. next = {l[14:0], fb}. It advances only on accept, in every mode.
- r0 = lfsr % WIDTH. r1 = (r0 + 1 + (lfsr[15:8] % (WIDTH-1))) % WIDTH. Both use the pre-advance lfsr value, and r1 != r0 always.
- mode 000 pass: mask=0.
- mode 001 single: bit pos0.
- mode 010 double: bits pos0, pos1.
- mode 011 random single: bit r0.
- mode 100 random double: bits r0, r1.
- mode 101 burst: bits (pos0+k) % WIDTH for k=0..BURST-1, wrapping past the MSB. pos0 >= WIDTH gives mask=0.
- mode 110 periodic: per_cnt increments on each accepted mode-110 word. When per_cnt == period-1: mask = bit r0 and per_cnt <= 0. Otherwise mask=0. period=0 means never inject and per_cnt holds 0. Accepting a non-110 word clears per_cnt.
- mode 111 reserved: treated as 000.
- inj_count increments on accept when mask != 0. It saturates at all-ones.
- in_valid=0 during a stall has no effect. Inputs are ignored when accept=0.

Test Plan:
- Reset, then IN=0, mode=000 with out_ready=1 -> next cycle out_valid=1, OUT=0, flip_mask=0, inj_count=0; in_ready=1 throughout.
- IN=0, mode=001, pos0=5 -> OUT=72'h20, inj_count=1. Then IN=1, mode=010, pos0=0, pos1=71 -> OUT has bit 71 set and bit 0 cleared. pos0=pos1=3 -> exactly one flip at bit 3.
- mode=101, pos0=70, BURST=4, IN=0 -> flip_mask bits {70,71,0,1} set.
- mode=100 for 1000 words, compared against a bench LFSR model seeded 16'hACE1 -> every mask popcount=2, positions < 72 and matching the model; inj_count=1000.
- mode=110, period=3, 9 words of IN=0 -> injections on words 3, 6 and 9 only, each popcount=1; inj_count=3. period=0 -> no injections.
- Backpressure: out_ready=0 for 3 cycles with in_valid=1 -> in_ready=0, OUT stable, LFSR not advanced. Assert rst mid-stall -> out_valid=0 next cycle and inj_count=0.
